// File: rtl/seq_mult.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// WIDTH steps per operation, with a valid/ready handshake on both sides.
module seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_reg, state_next;
   logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
   logic [WIDTH-1:0]     mplier_reg, mplier_next;
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [2*WIDTH-1:0]   product_reg, product_next;
   logic [2*WIDTH-1:0]   step_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
      end
   end

   // Accumulator value after the current step; also the final product on the last step.
   assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_comb begin
      state_next   = state_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               mcand_next  = {{WIDTH{1'b0}}, a};
               mplier_next = b;
               acc_next    = '0;
               cnt_next    = '0;
               state_next  = BUSY;
            end
         end
         BUSY: begin
            acc_next    = step_sum;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_STEP) begin
               product_next = step_sum;
               state_next   = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg == BUSY);
   assign out_valid = (state_reg == DONE);
   assign product   = product_reg;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=4): latency, backpressure,
// ignored inputs, asynchronous reset and an exhaustive back-to-back sweep.
module tb_seq_mult;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] product;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] last_prod;

   seq_mult #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one operation and follow it to DONE. The accepting edge counts as the
   // first edge: busy for 4 cycles, result visible after the 4th following edge.
   // With noise set, a=15/b=15/in_valid=1 are driven for the whole operation.
   task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input bit noise);
      logic [7:0] exp_p;
      exp_p = {4'b0, ia} * {4'b0, ib};
      chk("in_ready_idle", in_ready, 1);
      a = ia;
      b = ib;
      in_valid = 1'b1;
      @(negedge clk);
      if (noise) begin
         a = 4'd15;
         b = 4'd15;
         in_valid = 1'b1;
      end else begin
         in_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         chk("busy_high", busy, 1);
         chk("in_ready_busy", in_ready, 0);
         chk("out_valid_early", out_valid, 0);
         chk("product_no_partial", product, last_prod);
         @(negedge clk);
      end
      chk("busy_done", busy, 0);
      chk("out_valid_done", out_valid, 1);
      chk("product", product, exp_p);
      last_prod = exp_p;
      $display("op a=%0d b=%0d product=%0d expected=%0d", ia, ib, product, exp_p);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_consume", out_valid, 0);
      chk("in_ready_after_consume", in_ready, 1);
   endtask

   initial begin
      int idx;
      int done_cnt;
      int last_t;
      logic [7:0] inflight_exp;

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      last_prod = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 0);
      rst = 1'b1;

      // Basic and zero/one operands
      run_op(4'd15, 4'd15, 1'b0);
      consume();
      run_op(4'd0, 4'd9, 1'b0);
      consume();
      run_op(4'd7, 4'd1, 1'b0);
      consume();
      run_op(4'd1, 4'd8, 1'b0);
      consume();

      // Backpressure; the consuming cycle also presents new operands that must be refused
      run_op(4'd12, 4'd13, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_product", product, 156);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 4'd1;
      b = 4'd1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consume_to_idle", in_ready, 1);
      chk("no_accept_in_done", busy, 0);
      $display("backpressure released product=%0d", product);
      run_op(4'd1, 4'd1, 1'b0);
      consume();

      // Operand noise during BUSY/DONE is ignored, then accepted once back in IDLE
      run_op(4'd3, 4'd5, 1'b1);
      consume();
      run_op(4'd15, 4'd15, 1'b0);
      consume();

      // Asynchronous reset two cycles into BUSY
      a = 4'd9;
      b = 4'd9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_product", product, 0);
      chk("async_rst_in_ready", in_ready, 1);
      last_prod = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_out_valid", out_valid, 0);
      end
      rst = 1'b1;
      $display("mid-busy reset applied and released");
      run_op(4'd2, 4'd3, 1'b0);
      consume();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_out_valid", out_valid, 0);
      end

      // Exhaustive back-to-back sweep with out_ready held high
      idx = 0;
      done_cnt = 0;
      last_t = 0;
      inflight_exp = '0;
      out_ready = 1'b1;
      in_valid = 1'b0;
      for (int t = 0; t < 2000 && done_cnt < 256; t++) begin
         if (out_valid) begin
            chk("sweep_product", product, inflight_exp);
            $display("sweep op=%0d product=%0d expected=%0d", done_cnt, product, inflight_exp);
            done_cnt++;
         end
         if (in_ready && idx < 256) begin
            a = 4'(idx >> 4);
            b = 4'(idx);
            inflight_exp = {4'b0, a} * {4'b0, b};
            in_valid = 1'b1;
            if (idx > 0) chk("sweep_interval", t - last_t, 6);
            last_t = t;
            idx++;
         end else if (in_ready) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("sweep_completed", done_cnt, 256);
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
